// File: rtl/guess_game_ctrl_if.sv
// guess_game_ctrl_if: button/switch inputs and display/status outputs of the guessing-game controller.
interface guess_game_ctrl_if;
    logic        i_start_btn;
    logic        i_guess_btn;
    logic [3:0]  i_guess_val;
    logic [15:0] o_disp_val;
    logic [3:0]  o_tries_left;
    logic        o_win;
    logic        o_lose;
    modport master (output i_start_btn, i_guess_btn, i_guess_val, input o_disp_val, o_tries_left, o_win, o_lose);
    modport slave (input i_start_btn, i_guess_btn, i_guess_val, output o_disp_val, o_tries_left, o_win, o_lose);
endinterface

// File: rtl/guess_game_ctrl.sv
// guess_game_ctrl: number-guessing game FSM driving a one-hot symbol bus for the 7-segment decoder.
module guess_game_ctrl #(
    parameter int HOLD_CYCLES = 100_000_000,
    parameter int MAX_TRIES   = 4
) (
    input logic clk,
    input logic rst,
    guess_game_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, GUESS, HI, LO, WIN, LOSE} state_t;
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
    localparam logic [3:0] TRIES_INIT = 4'(MAX_TRIES);
    state_t r_state, w_state_n;
    logic [3:0] r_ctr, r_secret, w_secret_n, r_tries, w_tries_n, w_idx;
    logic [HW-1:0] r_hold;
    logic [15:0] r_disp;
    logic r_start_q, r_guess_q, r_win, r_lose;
    logic w_start_e, w_guess_e, w_valid;
    assign w_start_e = bus.i_start_btn & ~r_start_q;
    assign w_guess_e = bus.i_guess_btn & ~r_guess_q;
    assign w_valid = bus.i_guess_val <= 4'd9;
    // Restart takes priority over any guess in the same cycle.
    always_comb begin
        w_state_n = r_state;
        w_tries_n = r_tries;
        w_secret_n = r_secret;
        if (w_start_e) begin
            w_state_n = GUESS;
            w_tries_n = TRIES_INIT;
            w_secret_n = r_ctr;
        end else begin
            case (r_state)
                GUESS: if (w_guess_e && w_valid) begin
                    if (bus.i_guess_val == r_secret) w_state_n = WIN;
                    else if (r_tries == 4'd1) begin
                        w_tries_n = 4'd0;
                        w_state_n = LOSE;
                    end else begin
                        w_tries_n = r_tries - 4'd1;
                        w_state_n = bus.i_guess_val > r_secret ? HI : LO;
                    end
                end
                HI, LO: if (r_hold == HOLD_LAST) w_state_n = GUESS;
                default: ;
            endcase
        end
        w_idx = r_state == IDLE  ? 4'd12 :
                r_state == GUESS ? (w_valid ? bus.i_guess_val : 4'd14) :
                r_state == HI    ? 4'd10 :
                r_state == LO    ? 4'd11 :
                r_state == WIN   ? 4'd13 : 4'd15;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ctr <= '0;
            r_secret <= '0;
            r_tries <= TRIES_INIT;
            r_hold <= '0;
            r_disp <= 16'h1000;
            r_start_q <= 1'b1;
            r_guess_q <= 1'b1;
            r_win <= 1'b0;
            r_lose <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_ctr <= r_ctr == 4'd9 ? 4'd0 : r_ctr + 4'd1;
            r_secret <= w_secret_n;
            r_tries <= w_tries_n;
            // Counter only runs while a verdict is shown, so it is zero on every HI/LO entry.
            r_hold <= (r_state == HI || r_state == LO) ? (r_hold == HOLD_MAX ? r_hold : r_hold + 1'b1) : '0;
            r_disp <= 16'd1 << w_idx;
            r_start_q <= bus.i_start_btn;
            r_guess_q <= bus.i_guess_btn;
            r_win <= w_state_n == WIN;
            r_lose <= w_state_n == LOSE;
        end
    end
    assign bus.o_disp_val = r_disp;
    assign bus.o_tries_left = r_tries;
    assign bus.o_win = r_win;
    assign bus.o_lose = r_lose;
endmodule

// File: tb/tb_guess_game_ctrl.sv
// tb_guess_game_ctrl: directed test of guess_game_ctrl with HOLD_CYCLES=3, MAX_TRIES=4.
module tb_guess_game_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_checks = 0;
    int n_errors = 0;
    logic [3:0] m_ctr;
    guess_game_ctrl_if bus ();
    guess_game_ctrl #(.HOLD_CYCLES(3), .MAX_TRIES(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    // Reference secret counter: 0 in the first cycle out of reset, mod 10.
    always @(posedge clk) m_ctr <= rst ? 4'd0 : (m_ctr == 4'd9 ? 4'd0 : m_ctr + 4'd1);
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask
    task automatic press_start(input logic [3:0] k);
        int n = 0;
        while (m_ctr != k && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("start_align", 32'(m_ctr), 32'(k));
        bus.i_start_btn = 1'b1;
        @(negedge clk);
        bus.i_start_btn = 1'b0;
    endtask
    task automatic press_guess(input logic [3:0] v);
        bus.i_guess_val = v;
        bus.i_guess_btn = 1'b1;
        @(negedge clk);
        bus.i_guess_btn = 1'b0;
    endtask
    task automatic wrong_guess(input logic [3:0] v, input logic [15:0] verdict, input logic [3:0] tries);
        press_guess(v);
        check("wg_tries", 32'(bus.o_tries_left), 32'(tries));
        @(negedge clk);
        check("wg_verdict", 32'(bus.o_disp_val), 32'(verdict));
        repeat (3) @(negedge clk);
        check("wg_back", 32'(bus.o_disp_val), 32'(16'd1 << v));
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
    initial begin
        bus.i_start_btn = 1'b1;
        bus.i_guess_btn = 1'b0;
        bus.i_guess_val = 4'd0;
        repeat (4) @(negedge clk);
        check("rst_disp", 32'(bus.o_disp_val), 32'h1000);
        check("rst_tries", 32'(bus.o_tries_left), 32'd4);
        check("rst_winlose", {bus.o_win, bus.o_lose}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("held_start_idle", 32'(bus.o_disp_val), 32'h1000);
        end
        bus.i_start_btn = 1'b0;
        @(negedge clk);
        press_start(4'd7);
        check("start_tries", 32'(bus.o_tries_left), 32'd4);
        press_guess(4'd3);
        check("g3_tries", 32'(bus.o_tries_left), 32'd3);
        check("g3_disp_guess", 32'(bus.o_disp_val), 32'h0008);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("g3_lo_hold", 32'(bus.o_disp_val), 32'h0800);
        end
        @(negedge clk);
        check("g3_back", 32'(bus.o_disp_val), 32'h0008);
        press_guess(4'd12);
        check("g12_disp", 32'(bus.o_disp_val), 32'h4000);
        check("g12_tries", 32'(bus.o_tries_left), 32'd3);
        @(negedge clk);
        check("g12_stay", 32'(bus.o_disp_val), 32'h4000);
        press_start(4'd7);
        check("restart_tries", 32'(bus.o_tries_left), 32'd4);
        wrong_guess(4'd9, 16'h0400, 4'd3);
        wrong_guess(4'd0, 16'h0800, 4'd2);
        wrong_guess(4'd8, 16'h0400, 4'd1);
        press_guess(4'd1);
        check("lose_tries", 32'(bus.o_tries_left), 32'd0);
        check("lose_flag", {bus.o_win, bus.o_lose}, 32'd1);
        @(negedge clk);
        check("lose_disp", 32'(bus.o_disp_val), 32'h8000);
        press_guess(4'd7);
        @(negedge clk);
        check("lose_ignore_disp", 32'(bus.o_disp_val), 32'h8000);
        check("lose_ignore_flag", {bus.o_win, bus.o_lose}, 32'd1);
        press_start(4'd7);
        check("s5_tries", 32'(bus.o_tries_left), 32'd4);
        check("s5_flags", {bus.o_win, bus.o_lose}, 32'd0);
        press_guess(4'd7);
        check("win_flag", {bus.o_win, bus.o_lose}, 32'd2);
        @(negedge clk);
        check("win_disp", 32'(bus.o_disp_val), 32'h2000);
        press_start(4'd2);
        check("win_restart_flag", {bus.o_win, bus.o_lose}, 32'd0);
        check("win_restart_tries", 32'(bus.o_tries_left), 32'd4);
        @(negedge clk);
        check("win_restart_disp", 32'(bus.o_disp_val), 32'h0080);
        while (m_ctr != 4'd5) @(negedge clk);
        bus.i_guess_val = 4'd2;
        bus.i_start_btn = 1'b1;
        bus.i_guess_btn = 1'b1;
        @(negedge clk);
        bus.i_start_btn = 1'b0;
        bus.i_guess_btn = 1'b0;
        check("both_tries", 32'(bus.o_tries_left), 32'd4);
        check("both_flags", {bus.o_win, bus.o_lose}, 32'd0);
        @(negedge clk);
        check("both_disp", 32'(bus.o_disp_val), 32'h0004);
        press_guess(4'd5);
        check("both_new_secret", {bus.o_win, bus.o_lose}, 32'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_disp", 32'(bus.o_disp_val), 32'h1000);
        check("midrst_flags", {bus.o_win, bus.o_lose}, 32'd0);
        check("midrst_tries", 32'(bus.o_tries_left), 32'd4);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
